// File: rtl/det_sched_pkg.sv
// rtl/det_sched_pkg.sv - shared types and constants for the detector stream scheduler
package det_sched_pkg;

  typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Sequence the external Mealy detector fires on (oldest bit first)
  localparam logic [3:0] DET_PATTERN = 4'b1101;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-request round-robin arbiter; pointer source wins a tie
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = (req == 2'b11) ? ptr : req[1];
    gnt     = 2'b00;
    if (en && (req != 2'b00)) begin
      gnt = gnt_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/det_stream_sched.sv
// rtl/det_stream_sched.sv - shares a serial 1101 detector between two word requesters
module det_stream_sched
  import det_sched_pkg::*;
#(
  parameter int WORD_W     = 16,
  parameter int FLUSH_BITS = 2,
  parameter int CNT_W      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [WORD_W-1:0] req_data_a,
  input  logic [WORD_W-1:0] req_data_b,
  output logic [1:0]        req_ready,
  output logic              det_i,
  input  logic              det_o,
  output logic              res_valid,
  output logic              res_src,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_hit,
  output logic [3:0]        res_first
);

  localparam int IDX_W = $clog2(WORD_W);
  localparam int FL_W  = $clog2(FLUSH_BITS + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_BITS - 1);

  state_t            state, state_nxt;
  logic              ptr;
  logic              src;
  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [3:0]        first, first_nxt;
  logic              found, found_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [FL_W-1:0]   flush_cnt;
  logic [1:0]        gnt;
  logic              gnt_idx;
  logic              arb_en;

  // Grants are only offered while idle and never during reset
  assign arb_en    = (state == IDLE) && !rst;
  assign req_ready = gnt;

  rr_arb2 u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    state_nxt = state;
    det_i     = 1'b0;
    count_nxt = count;
    first_nxt = first;
    found_nxt = found;
    unique case (state)
      IDLE:  if (gnt != 2'b00) state_nxt = FLUSH;
      FLUSH: if (flush_cnt == FL_LAST) state_nxt = SHIFT;
      SHIFT: begin
        det_i = word[bit_idx];
        if (det_o) begin
          if (count != '1) count_nxt = count + 1'b1;
          if (!found) begin
            found_nxt = 1'b1;
            first_nxt = 4'(bit_idx);
          end
        end
        if (bit_idx == IDX_LAST) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= SRC_A;
      src       <= SRC_A;
      word      <= '0;
      count     <= '0;
      first     <= '0;
      found     <= 1'b0;
      bit_idx   <= '0;
      flush_cnt <= '0;
      res_valid <= 1'b0;
      res_src   <= 1'b0;
      res_count <= '0;
      res_hit   <= 1'b0;
      res_first <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      first     <= first_nxt;
      found     <= found_nxt;
      res_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            word      <= gnt_idx ? req_data_b : req_data_a;
            src       <= gnt_idx;
            count     <= '0;
            first     <= '0;
            found     <= 1'b0;
            flush_cnt <= '0;
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          bit_idx   <= '0;
        end
        SHIFT: begin
          bit_idx <= bit_idx + 1'b1;
          // Results capture the last bit's match as well, so use the next-state values
          if (bit_idx == IDX_LAST) begin
            res_valid <= 1'b1;
            res_src   <= src;
            res_count <= count_nxt;
            res_hit   <= (count_nxt != '0);
            res_first <= first_nxt;
          end
        end
        DONE: ptr <= ~src;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_det_stream_sched.sv
// tb/tb_det_stream_sched.sv - directed bench with a behavioural 1101 Mealy detector
module tb_det_stream_sched;
  import det_sched_pkg::*;

  logic        tb_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [15:0] req_data_a = '0;
  logic [15:0] req_data_b = '0;
  logic [1:0]  req_ready;
  logic        det_i;
  logic        det_o;
  logic        res_valid;
  logic        res_src;
  logic [4:0]  res_count;
  logic        res_hit;
  logic [3:0]  res_first;

  int checks = 0;
  int failures = 0;

  always #5 tb_clk = ~tb_clk;

  det_stream_sched dut (
    .clk        (tb_clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data_a (req_data_a),
    .req_data_b (req_data_b),
    .req_ready  (req_ready),
    .det_i      (det_i),
    .det_o      (det_o),
    .res_valid  (res_valid),
    .res_src    (res_src),
    .res_count  (res_count),
    .res_hit    (res_hit),
    .res_first  (res_first)
  );

  // Overlapping 1101 Mealy detector: states 0="",1="1",2="11",3="110"
  logic [1:0] det_st = 2'd0;
  assign det_o = (det_st == 2'd3) && det_i;
  always @(posedge tb_clk) begin
    case (det_st)
      2'd0: det_st <= det_i ? 2'd1 : 2'd0;
      2'd1: det_st <= det_i ? 2'd2 : 2'd0;
      2'd2: det_st <= det_i ? 2'd2 : 2'd3;
      default: det_st <= det_i ? 2'd1 : 2'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic wait_grant();
    bit seen = 1'b0;
    #1;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (req_ready != 2'b00) seen = 1'b1;
      else step();
    end
    chk("grant_seen", {31'd0, seen}, 32'd1);
  endtask

  // Entered on the grant cycle T; returns on cycle T+20
  task automatic run_txn(input logic [1:0] exp_gnt, input logic [15:0] word,
                         input logic exp_src, input logic [4:0] exp_cnt,
                         input logic [3:0] exp_first, input bit clear_req);
    chk("gnt", {30'd0, req_ready}, {30'd0, exp_gnt});
    step();
    if (clear_req) req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      chk("flush_det_i", {31'd0, det_i}, 32'd0);
      chk("ready_busy", {30'd0, req_ready}, 32'd0);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("shift_det_i[%0d]", i), {31'd0, det_i}, {31'd0, word[i]});
      chk("res_valid_early", {31'd0, res_valid}, 32'd0);
      step();
    end
    chk("res_valid", {31'd0, res_valid}, 32'd1);
    chk("res_src", {31'd0, res_src}, {31'd0, exp_src});
    chk("res_count", {27'd0, res_count}, {27'd0, exp_cnt});
    chk("res_hit", {31'd0, res_hit}, {31'd0, (exp_cnt != 5'd0)});
    chk("res_first", {28'd0, res_first}, {28'd0, exp_first});
    step();
    chk("res_valid_drop", {31'd0, res_valid}, 32'd0);
    chk("res_count_hold", {27'd0, res_count}, {27'd0, exp_cnt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bit seen_res;

    do_reset();
    rst = 1'b1;
    step();
    chk("rst_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_det_i", {31'd0, det_i}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_res_src", {31'd0, res_src}, 32'd0);
    chk("rst_res_count", {27'd0, res_count}, 32'd0);
    chk("rst_res_hit", {31'd0, res_hit}, 32'd0);
    chk("rst_res_first", {28'd0, res_first}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_req", {30'd0, req_ready}, 32'd0);

    req_data_a = 16'h000B; req_valid = 2'b01;
    wait_grant();
    run_txn(2'b01, 16'h000B, SRC_A, 5'd1, 4'd3, 1'b1);

    req_data_a = 16'h006D; req_valid = 2'b01;
    wait_grant();
    run_txn(2'b01, 16'h006D, SRC_A, 5'd1, 4'd5, 1'b1);

    req_data_a = 16'hFFFF; req_valid = 2'b01;
    wait_grant();
    run_txn(2'b01, 16'hFFFF, SRC_A, 5'd0, 4'd0, 1'b1);

    req_data_a = 16'h0000; req_valid = 2'b01;
    wait_grant();
    run_txn(2'b01, 16'h0000, SRC_A, 5'd0, 4'd0, 1'b1);

    req_data_a = 16'hB6DB; req_valid = 2'b01;
    wait_grant();
    run_txn(2'b01, 16'hB6DB, SRC_A, 5'd5, 4'd3, 1'b1);

    // Both held from reset: A, B, A with each grant right after the previous strobe
    do_reset();
    req_data_a = 16'h000B; req_data_b = 16'h006D; req_valid = 2'b11;
    wait_grant();
    run_txn(2'b01, 16'h000B, SRC_A, 5'd1, 4'd3, 1'b0);
    run_txn(2'b10, 16'h006D, SRC_B, 5'd1, 4'd5, 1'b0);
    run_txn(2'b01, 16'h000B, SRC_A, 5'd1, 4'd3, 1'b1);

    // Reset while shifting bit 8 of B6DB
    req_data_a = 16'hB6DB; req_valid = 2'b01;
    wait_grant();
    chk("mid_gnt", {30'd0, req_ready}, 32'd1);
    step();
    req_valid = 2'b00;
    for (int i = 0; i < 10; i++) step();
    chk("mid_det_i_bit8", {31'd0, det_i}, 32'd0);
    rst = 1'b1;
    step();
    chk("mid_rst_ready", {30'd0, req_ready}, 32'd0);
    chk("mid_rst_det_i", {31'd0, det_i}, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_res_count", {27'd0, res_count}, 32'd0);
    chk("mid_rst_res_src", {31'd0, res_src}, 32'd0);
    chk("mid_rst_res_hit", {31'd0, res_hit}, 32'd0);
    chk("mid_rst_res_first", {28'd0, res_first}, 32'd0);
    rst = 1'b0;
    seen_res = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (res_valid) seen_res = 1'b1;
    end
    chk("no_res_after_rst", {31'd0, seen_res}, 32'd0);

    req_data_b = 16'h000B; req_valid = 2'b10;
    wait_grant();
    run_txn(2'b10, 16'h000B, SRC_B, 5'd1, 4'd3, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
